// File: rtl/mole_scheduler_pkg.sv
// Shared types, LED codes and hole-picking helper for the mole game sequencer.
package mole_scheduler_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StGap  = 3'd1,
        StUp   = 3'd2,
        StHit  = 3'd3,
        StMiss = 3'd4
    } state_t;

    localparam int unsigned NUM_HOLES = 9;

    // LED code layout is {blue_duty, red_duty}
    localparam logic [15:0] CODE_OFF  = 16'h0000;
    localparam logic [15:0] CODE_MOLE = 16'hFF00;
    localparam logic [15:0] CODE_HIT  = 16'h00FF;
    localparam logic [15:0] CODE_MISS = 16'h2020;

    // Fold a 4-bit random value onto 0..8, then step past the previous hole so
    // the same hole never lights twice in a row.
    function automatic logic [3:0] pick_hole(input logic [3:0] r, input logic [3:0] prev);
        logic [3:0] cand;
        cand = (r < 4'd9) ? r : r - 4'd9;
        if (cand == prev) begin
            cand = (cand == 4'd8) ? 4'd0 : cand + 4'd1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side bundle: enable/button inputs in, LED codes and counters out.
interface mole_scheduler_if;
    import mole_scheduler_pkg::*;

    logic                            enable;
    logic                            hit_valid;
    logic [3:0]                      hit_idx;
    logic [NUM_HOLES-1:0][15:0]      code;
    logic [3:0]                      mole_idx;
    logic                            active;
    logic [7:0]                      score;
    logic [7:0]                      misses;

    modport master (
        output enable, hit_valid, hit_idx,
        input  code, mole_idx, active, score, misses
    );

    modport slave (
        input  enable, hit_valid, hit_idx,
        output code, mole_idx, active, score, misses
    );

endinterface

// File: rtl/mole_scheduler_lfsr.sv
// 16-bit Galois LFSR (taps 16'hB400), free-running every clock.
module mole_scheduler_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_d;

    // Shift right, fold taps back in when the bit shifted out is set
    always_comb begin
        w_lfsr_d = {1'b0, r_lfsr[15:1]};
        if (r_lfsr[0]) begin
            w_lfsr_d = w_lfsr_d ^ 16'hB400;
        end
    end

    // State register, reset to the non-zero seed
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_d;
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: tick timer, game FSM, hole picker, counters and LED code registers.
module mole_scheduler
    import mole_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned MOLE_TICKS  = 1000,
    parameter int unsigned GAP_TICKS   = 250,
    parameter int unsigned FLASH_TICKS = 200,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   i_clock,
    input  logic                   i_resetn,
    mole_scheduler_if.slave        io_game
);

    localparam logic [15:0] DIV_LAST   = 16'(TICK_DIV - 1);
    localparam logic [15:0] MOLE_LAST  = 16'(MOLE_TICKS - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_TICKS - 1);
    localparam logic [15:0] FLASH_LAST = 16'(FLASH_TICKS - 1);

    state_t                     r_state, w_state_d;
    logic [15:0]                r_presc, r_ticks;
    logic                       w_tick, w_hit_ok, w_hit, w_miss;
    logic [15:0]                w_lfsr;
    logic [3:0]                 r_mole, w_mole_d;
    logic [7:0]                 r_score, r_misses;
    logic [NUM_HOLES-1:0][15:0] r_code, w_code_d;
    logic                       r_active;

    mole_scheduler_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clock  (i_clock),
        .i_resetn (i_resetn),
        .o_value  (w_lfsr)
    );

    assign w_tick   = (r_presc == DIV_LAST);
    assign w_hit_ok = io_game.hit_valid && (io_game.hit_idx < 4'(NUM_HOLES))
                      && (io_game.hit_idx == r_mole);

    // Next-state: hit beats the final UP tick; disable overrides everything
    always_comb begin
        w_state_d = r_state;
        w_hit     = 1'b0;
        w_miss    = 1'b0;
        case (r_state)
            StIdle: if (io_game.enable) w_state_d = StGap;
            StGap:  if (w_tick && r_ticks == GAP_LAST) w_state_d = StUp;
            StUp: begin
                if (w_hit_ok) begin
                    w_state_d = StHit;
                    w_hit     = 1'b1;
                end else if (w_tick && r_ticks == MOLE_LAST) begin
                    w_state_d = StMiss;
                    w_miss    = 1'b1;
                end
            end
            StHit, StMiss: if (w_tick && r_ticks == FLASH_LAST) w_state_d = StGap;
            default: w_state_d = StIdle;
        endcase
        if (!io_game.enable) begin
            w_state_d = StIdle;
            w_hit     = 1'b0;
            w_miss    = 1'b0;
        end
    end

    // New hole is chosen only on the GAP -> UP edge
    always_comb begin
        w_mole_d = r_mole;
        if (r_state == StGap && w_state_d == StUp) begin
            w_mole_d = pick_hole(w_lfsr[3:0], r_mole);
        end
    end

    // Codes are built from next state so they change on the same edge as the state
    always_comb begin
        w_code_d = '0;
        case (w_state_d)
            StUp:    w_code_d[w_mole_d] = CODE_MOLE;
            StHit:   w_code_d[w_mole_d] = CODE_HIT;
            StMiss:  w_code_d[w_mole_d] = CODE_MISS;
            default: w_code_d = '0;
        endcase
    end

    // Prescaler and tick timer restart on every state entry and sit cleared in IDLE
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if (w_state_d != r_state || r_state == StIdle) begin
            r_presc <= '0;
            r_ticks <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ticks <= r_ticks + 16'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // State, hole, output codes and the UP indicator
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state  <= StIdle;
            r_mole   <= 4'd0;
            r_code   <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_mole   <= w_mole_d;
            r_code   <= w_code_d;
            r_active <= (w_state_d == StUp);
        end
    end

    // Saturating counters, cleared when a new game starts
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_score  <= 8'd0;
            r_misses <= 8'd0;
        end else if (r_state == StIdle && w_state_d == StGap) begin
            r_score  <= 8'd0;
            r_misses <= 8'd0;
        end else begin
            if (w_hit && r_score != 8'hFF)   r_score  <= r_score + 8'd1;
            if (w_miss && r_misses != 8'hFF) r_misses <= r_misses + 8'd1;
        end
    end

    assign io_game.code     = r_code;
    assign io_game.mole_idx = r_mole;
    assign io_game.active   = r_active;
    assign io_game.score    = r_score;
    assign io_game.misses   = r_misses;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with small timing parameters and an LFSR model.
module tb_mole_scheduler;

    logic i_clock = 1'b0;
    logic i_resetn;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    logic [3:0]  exp_mole;
    logic [3:0]  prev_mole;
    int          exp_score;
    int          exp_misses;

    mole_scheduler_if bus ();

    mole_scheduler #(
        .TICK_DIV    (4),
        .MOLE_TICKS  (5),
        .GAP_TICKS   (2),
        .FLASH_TICKS (3),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .i_clock  (i_clock),
        .i_resetn (i_resetn),
        .io_game  (bus)
    );

    always #5 i_clock = ~i_clock;

    // Reference Galois LFSR, advanced on the same edges as the design
    always @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_codes(input string tag, input logic [3:0] idx, input logic [15:0] val);
        logic [8:0][15:0] e;
        e = '0;
        if (val != 16'h0000) e[idx] = val;
        checks++;
        assert (bus.code === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.code, e);
        end
    endtask

    // Expected hole for the upcoming GAP->UP edge, from the model LFSR value now
    task automatic predict();
        int c;
        prev_mole = exp_mole;
        c = int'(m_lfsr[3:0]) % 9;
        if (c == int'(exp_mole)) c = (c + 1) % 9;
        exp_mole = 4'(c);
    endtask

    task automatic chk_up(input string tag);
        chk_codes(tag, exp_mole, 16'hFF00);
        chk({tag, "_active"}, 32'(bus.active), 32'd1);
        chk({tag, "_idx"}, 32'(bus.mole_idx), 32'(exp_mole));
    endtask

    initial begin
        i_resetn      = 1'b0;
        bus.enable    = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_idx   = 4'd0;
        exp_mole      = 4'd0;
        prev_mole     = 4'd0;
        step(2);
        i_resetn = 1'b1;
        step(1);
        chk_codes("reset_codes", 4'd0, 16'h0000);
        chk("reset_idx", 32'(bus.mole_idx), 32'd0);
        chk("reset_active", 32'(bus.active), 32'd0);
        chk("reset_score", 32'(bus.score), 32'd0);
        chk("reset_misses", 32'(bus.misses), 32'd0);

        // First mole: 8 dark clocks of GAP, then UP
        bus.enable = 1'b1;
        step(1);
        chk_codes("gap_first", 4'd0, 16'h0000);
        step(7);
        chk_codes("gap_last", 4'd0, 16'h0000);
        predict();
        step(1);
        chk_up("up1");

        // Correct hit, flash lasts 12 clocks
        bus.hit_valid = 1'b1;
        bus.hit_idx   = exp_mole;
        step(1);
        bus.hit_valid = 1'b0;
        chk_codes("hit1", exp_mole, 16'h00FF);
        chk("hit1_score", 32'(bus.score), 32'd1);
        chk("hit1_active", 32'(bus.active), 32'd0);
        step(11);
        chk_codes("hit1_end", exp_mole, 16'h00FF);
        step(1);
        chk_codes("hit1_gap", 4'd0, 16'h0000);

        // Hit during GAP is ignored
        step(1);
        bus.hit_valid = 1'b1;
        bus.hit_idx   = exp_mole;
        step(1);
        bus.hit_valid = 1'b0;
        chk_codes("gap_hit", 4'd0, 16'h0000);
        chk("gap_hit_score", 32'(bus.score), 32'd1);
        step(5);
        predict();
        step(1);
        chk_up("up2");
        chk("up2_norepeat", 32'(bus.mole_idx != prev_mole), 32'd1);

        // Wrong index then out-of-range index: ignored
        bus.hit_valid = 1'b1;
        bus.hit_idx   = (exp_mole == 4'd8) ? 4'd0 : exp_mole + 4'd1;
        step(1);
        bus.hit_idx = 4'd12;
        step(1);
        bus.hit_valid = 1'b0;
        chk_codes("bad_hit", exp_mole, 16'hFF00);
        chk("bad_hit_score", 32'(bus.score), 32'd1);
        chk("bad_hit_misses", 32'(bus.misses), 32'd0);
        step(17);
        chk_codes("up2_last", exp_mole, 16'hFF00);
        step(1);
        chk_codes("miss1", exp_mole, 16'h2020);
        chk("miss1_misses", 32'(bus.misses), 32'd1);
        chk("miss1_score", 32'(bus.score), 32'd1);
        chk("miss1_active", 32'(bus.active), 32'd0);

        // Hit on the final UP cycle wins over timeout
        step(12);
        step(7);
        predict();
        step(1);
        chk_up("up3");
        step(19);
        chk_codes("up3_last", exp_mole, 16'hFF00);
        bus.hit_valid = 1'b1;
        bus.hit_idx   = exp_mole;
        step(1);
        bus.hit_valid = 1'b0;
        chk_codes("edge_hit", exp_mole, 16'h00FF);
        chk("edge_hit_score", 32'(bus.score), 32'd2);
        chk("edge_hit_misses", 32'(bus.misses), 32'd1);
        step(12);

        // 300 hit moles: exact hole sequence, no repeats, score saturates
        exp_score = 2;
        for (int i = 0; i < 300; i++) begin
            step(7);
            predict();
            step(1);
            chk_up("run_up");
            chk("run_norepeat", 32'(bus.mole_idx != prev_mole), 32'd1);
            bus.hit_valid = 1'b1;
            bus.hit_idx   = exp_mole;
            step(1);
            bus.hit_valid = 1'b0;
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            chk_codes("run_hit", exp_mole, 16'h00FF);
            chk("run_score", 32'(bus.score), 32'(exp_score));
            step(12);
        end

        // 256 missed moles: misses saturates, score holds
        exp_misses = 1;
        for (int i = 0; i < 256; i++) begin
            step(7);
            predict();
            step(1);
            chk("miss_run_idx", 32'(bus.mole_idx), 32'(exp_mole));
            step(20);
            exp_misses = (exp_misses < 255) ? exp_misses + 1 : 255;
            chk_codes("miss_run", exp_mole, 16'h2020);
            chk("miss_run_misses", 32'(bus.misses), 32'(exp_misses));
            chk("miss_run_score", 32'(bus.score), 32'd255);
            step(12);
        end

        // Drop enable in UP
        step(7);
        predict();
        step(1);
        chk_up("up_dis");
        bus.enable = 1'b0;
        step(1);
        chk_codes("dis_codes", 4'd0, 16'h0000);
        chk("dis_active", 32'(bus.active), 32'd0);
        chk("dis_score", 32'(bus.score), 32'd255);
        bus.enable = 1'b1;
        step(1);
        chk("reen_score", 32'(bus.score), 32'd0);
        chk("reen_misses", 32'(bus.misses), 32'd0);
        chk_codes("reen_codes", 4'd0, 16'h0000);
        step(7);
        predict();
        step(1);
        chk_up("up_reen");
        bus.hit_valid = 1'b1;
        bus.hit_idx   = exp_mole;
        step(1);
        bus.hit_valid = 1'b0;
        chk_codes("reen_hit", exp_mole, 16'h00FF);
        chk("reen_hit_score", 32'(bus.score), 32'd1);

        // Asynchronous reset mid-flash
        step(2);
        i_resetn = 1'b0;
        #1;
        chk_codes("arst_codes", 4'd0, 16'h0000);
        chk("arst_active", 32'(bus.active), 32'd0);
        chk("arst_score", 32'(bus.score), 32'd0);
        chk("arst_misses", 32'(bus.misses), 32'd0);
        chk("arst_idx", 32'(bus.mole_idx), 32'd0);
        exp_mole = 4'd0;
        step(1);
        i_resetn = 1'b1;
        step(1);
        chk_codes("post_rst_gap", 4'd0, 16'h0000);
        step(7);
        predict();
        step(1);
        chk_up("post_rst_up");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
